// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write arbiter.
package regfile_pkg;

  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 16;

  // Sequencer states: clear every register, then serve requesters.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // One pending register-file write.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wreq_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester handshakes plus the register-file write port.
interface regfile_write_arbiter_if;
  import regfile_pkg::*;

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  logic              rf_wen;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              init_busy;

  // Requester / observer side.
  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  rf_wen, rf_waddr, rf_wdata, init_busy
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output rf_wen, rf_waddr, rf_wdata, init_busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the favoured requester
// and flips only when both request at once while enabled.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_valid,
  output logic [1:0] o_grant
);

  logic r_ptr;

  // Grant the lone requester, or the pointer's choice when contested.
  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = r_ptr ? 2'b10 : 2'b01;
      default: o_grant = 2'b00;
    endcase
  end

  // After a contested grant, favour the requester that lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (i_en && (i_valid == 2'b11)) begin
      r_ptr <= o_grant[0];
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: clears all registers after reset,
// then forwards requester writes through registered outputs.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter bit ZERO_REG = 1'b1
) (
  input logic                    clk,
  input logic                    rst,
  regfile_write_arbiter_if.slave bus
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_wen;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_run;
  logic [1:0]        w_grant;
  logic              w_xfer;
  wreq_t             w_req0;
  wreq_t             w_req1;
  wreq_t             w_sel;

  assign w_run  = (r_state == RUN);
  assign w_req0 = {bus.req0_addr, bus.req0_data};
  assign w_req1 = {bus.req1_addr, bus.req1_data};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_run),
    .i_valid ({bus.req1_valid, bus.req0_valid}),
    .o_grant (w_grant)
  );

  assign bus.req0_ready = w_run & bus.req0_valid & w_grant[0];
  assign bus.req1_ready = w_run & bus.req1_valid & w_grant[1];
  assign w_xfer         = bus.req0_ready | bus.req1_ready;

  // Route the granted requester's address and data to the output registers.
  always_comb begin
    w_sel = w_req0;
    if (w_grant[1]) begin
      w_sel = w_req1;
    end else begin
      w_sel = w_req0;
    end
  end

  // Sequencer: clear sweep in INIT, then register one granted write per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= INIT;
      r_cnt   <= {ADDR_W{1'b0}};
      r_wen   <= 1'b0;
      r_waddr <= {ADDR_W{1'b0}};
      r_wdata <= {DATA_W{1'b0}};
    end else begin
      case (r_state)
        INIT: begin
          r_wen   <= 1'b1;
          r_waddr <= r_cnt;
          r_wdata <= {DATA_W{1'b0}};
          r_cnt   <= r_cnt + ADDR_W'(1);
          if (r_cnt == ADDR_W'(NUM_REGS - 1)) begin
            r_state <= RUN;
          end else begin
            r_state <= INIT;
          end
        end
        RUN: begin
          if (w_xfer) begin
            // Writes to the hard-wired zero register complete but are dropped.
            r_wen   <= ~(ZERO_REG && (w_sel.addr == {ADDR_W{1'b0}}));
            r_waddr <= w_sel.addr;
            r_wdata <= w_sel.data;
          end else begin
            r_wen   <= 1'b0;
            r_waddr <= r_waddr;
            r_wdata <= r_wdata;
          end
        end
        default: begin
          r_state <= INIT;
          r_cnt   <= {ADDR_W{1'b0}};
          r_wen   <= 1'b0;
          r_waddr <= {ADDR_W{1'b0}};
          r_wdata <= {DATA_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.rf_wen    = r_wen;
  assign bus.rf_waddr  = r_waddr;
  assign bus.rf_wdata  = r_wdata;
  assign bus.init_busy = (r_state == INIT);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed, table-driven bench for regfile_write_arbiter.
module tb_regfile_write_arbiter;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  regfile_write_arbiter_if bus();

  regfile_write_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic [3:0]  a0;
    logic [15:0] d0;
    logic        v1;
    logic [3:0]  a1;
    logic [15:0] d1;
    logic        r0;
    logic        r1;
    logic        wen;
    logic        chk_ad;
    logic [3:0]  waddr;
    logic [15:0] wdata;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic v0, input logic [3:0] a0, input logic [15:0] d0,
                              input logic v1, input logic [3:0] a1, input logic [15:0] d1,
                              input logic r0, input logic r1, input logic wen,
                              input logic chk_ad, input logic [3:0] waddr,
                              input logic [15:0] wdata);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.wen = wen;
    v.chk_ad = chk_ad; v.waddr = waddr; v.wdata = wdata;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [3:0] a0, input logic [15:0] d0,
                       input logic v1, input logic [3:0] a1, input logic [15:0] d1);
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
  endtask

  // Starts at a falling edge just after reset release; ends at the falling
  // edge following the 16th init write.
  task automatic run_init();
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("init_busy", 32'(bus.init_busy), 32'h1);
      chk("init_rdy0", 32'(bus.req0_ready), 32'h0);
      chk("init_rdy1", 32'(bus.req1_ready), 32'h0);
      @(posedge clk); #1;
      chk("init_wen", 32'(bus.rf_wen), 32'h1);
      chk("init_waddr", 32'(bus.rf_waddr), 32'(i));
      chk("init_wdata", 32'(bus.rf_wdata), 32'h0);
      @(negedge clk);
    end
    chk("init_busy_fall", 32'(bus.init_busy), 32'h0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    drive(1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);

    // Vectors applied in RUN, starting with the pointer favouring req0.
    vecs[0]  = mk(1'b1, 4'h3, 16'hBEEF, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'h3, 16'hBEEF);
    vecs[1]  = mk(1'b1, 4'h1, 16'h1111, 1'b1, 4'h2, 16'h2222, 1'b1, 1'b0, 1'b1, 1'b1, 4'h1, 16'h1111);
    vecs[2]  = mk(1'b1, 4'h1, 16'h1111, 1'b1, 4'h2, 16'h2222, 1'b0, 1'b1, 1'b1, 1'b1, 4'h2, 16'h2222);
    vecs[3]  = mk(1'b1, 4'h1, 16'h1111, 1'b1, 4'h2, 16'h2222, 1'b1, 1'b0, 1'b1, 1'b1, 4'h1, 16'h1111);
    vecs[4]  = mk(1'b1, 4'h1, 16'h1111, 1'b1, 4'h2, 16'h2222, 1'b0, 1'b1, 1'b1, 1'b1, 4'h2, 16'h2222);
    vecs[5]  = mk(1'b1, 4'h1, 16'h1111, 1'b1, 4'h2, 16'h2222, 1'b1, 1'b0, 1'b1, 1'b1, 4'h1, 16'h1111);
    vecs[6]  = mk(1'b1, 4'h1, 16'h1111, 1'b1, 4'h2, 16'h2222, 1'b0, 1'b1, 1'b1, 1'b1, 4'h2, 16'h2222);
    vecs[7]  = mk(1'b1, 4'h1, 16'h1111, 1'b1, 4'h2, 16'h2222, 1'b1, 1'b0, 1'b1, 1'b1, 4'h1, 16'h1111);
    vecs[8]  = mk(1'b0, 4'h0, 16'h0000, 1'b1, 4'h4, 16'h4444, 1'b0, 1'b1, 1'b1, 1'b1, 4'h4, 16'h4444);
    vecs[9]  = mk(1'b0, 4'h0, 16'h0000, 1'b1, 4'h4, 16'h4444, 1'b0, 1'b1, 1'b1, 1'b1, 4'h4, 16'h4444);
    vecs[10] = mk(1'b0, 4'h0, 16'h0000, 1'b1, 4'h4, 16'h4444, 1'b0, 1'b1, 1'b1, 1'b1, 4'h4, 16'h4444);
    vecs[11] = mk(1'b1, 4'h1, 16'h1111, 1'b1, 4'h4, 16'h4444, 1'b0, 1'b1, 1'b1, 1'b1, 4'h4, 16'h4444);
    vecs[12] = mk(1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'h4, 16'h4444);
    vecs[13] = mk(1'b1, 4'h0, 16'hFFFF, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
    vecs[14] = mk(1'b1, 4'h5, 16'h5555, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'h5, 16'h5555);
    vecs[15] = mk(1'b1, 4'h9, 16'hAAAA, 1'b1, 4'h9, 16'hBBBB, 1'b1, 1'b0, 1'b1, 1'b1, 4'h9, 16'hAAAA);
    vecs[16] = mk(1'b0, 4'h0, 16'h0000, 1'b1, 4'h9, 16'hBBBB, 1'b0, 1'b1, 1'b1, 1'b1, 4'h9, 16'hBBBB);
    vecs[17] = mk(1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'h9, 16'hBBBB);

    // Reset state.
    @(negedge clk);
    chk("rst_wen", 32'(bus.rf_wen), 32'h0);
    chk("rst_waddr", 32'(bus.rf_waddr), 32'h0);
    chk("rst_wdata", 32'(bus.rf_wdata), 32'h0);
    chk("rst_busy", 32'(bus.init_busy), 32'h1);
    rst = 1'b0;

    // Clear sweep with no requests, then an idle RUN cycle.
    run_init();
    @(posedge clk); #1;
    chk("idle_wen", 32'(bus.rf_wen), 32'h0);
    @(negedge clk);

    // Table-driven RUN vectors.
    for (int k = 0; k < NV; k++) begin
      drive(vecs[k].v0, vecs[k].a0, vecs[k].d0, vecs[k].v1, vecs[k].a1, vecs[k].d1);
      #1;
      chk($sformatf("v%0d_rdy0", k), 32'(bus.req0_ready), 32'(vecs[k].r0));
      chk($sformatf("v%0d_rdy1", k), 32'(bus.req1_ready), 32'(vecs[k].r1));
      @(posedge clk); #1;
      chk($sformatf("v%0d_wen", k), 32'(bus.rf_wen), 32'(vecs[k].wen));
      if (vecs[k].chk_ad) begin
        chk($sformatf("v%0d_waddr", k), 32'(bus.rf_waddr), 32'(vecs[k].waddr));
        chk($sformatf("v%0d_wdata", k), 32'(bus.rf_wdata), 32'(vecs[k].wdata));
      end
      @(negedge clk);
    end

    // Reset asserted mid-RUN while a write is on the port.
    drive(1'b0, 4'h0, 16'h0000, 1'b1, 4'h6, 16'h6666);
    #1;
    chk("mid_rdy1", 32'(bus.req1_ready), 32'h1);
    @(posedge clk); #1;
    chk("mid_wen_pre", 32'(bus.rf_wen), 32'h1);
    chk("mid_waddr_pre", 32'(bus.rf_waddr), 32'h6);
    #2 rst = 1'b1;
    #1;
    chk("mid_wen_rst", 32'(bus.rf_wen), 32'h0);
    chk("mid_waddr_rst", 32'(bus.rf_waddr), 32'h0);
    chk("mid_wdata_rst", 32'(bus.rf_wdata), 32'h0);
    chk("mid_busy_rst", 32'(bus.init_busy), 32'h1);
    chk("mid_rdy1_rst", 32'(bus.req1_ready), 32'h0);

    // req0 waits through the restarted clear sweep.
    drive(1'b1, 4'h3, 16'hBEEF, 1'b0, 4'h0, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_init();
    chk("first_run_rdy0", 32'(bus.req0_ready), 32'h1);
    @(posedge clk); #1;
    chk("first_run_wen", 32'(bus.rf_wen), 32'h1);
    chk("first_run_waddr", 32'(bus.rf_waddr), 32'h3);
    chk("first_run_wdata", 32'(bus.rf_wdata), 32'hBEEF);
    @(negedge clk);
    drive(1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);
    @(posedge clk); #1;
    chk("after_wen", 32'(bus.rf_wen), 32'h0);
    chk("after_wdata_hold", 32'(bus.rf_wdata), 32'hBEEF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
